// File: rtl/melody_sequencer.sv
// Melody step sequencer: plays a 16-entry pattern of {note, duration} steps,
// emitting a registered note code and gate with a short articulation gap per note.
module melody_sequencer #(
    parameter int TICKS_PER_BEAT = 5000000,
    parameter int GAP_TICKS      = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [3:0] last_step,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic [2:0] note,
    output logic       gate,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [TW-1:0] TICK_GAP  = TW'(TICKS_PER_BEAT - GAP_TICKS - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t          state_q;
    logic [5:0]      pattern_q [16];
    logic [TW-1:0]   tick_q;
    logic [2:0]      beat_q;
    logic [2:0]      dur_q;
    logic [3:0]      step_q;
    logic [2:0]      note_q;
    logic            gate_q;
    logic            busy_q;
    logic            done_q;

    logic [3:0]      load_idx_d;
    logic [5:0]      load_entry_d;
    logic            tick_wrap_d;
    logic            step_end_d;
    logic            gap_edge_d;

    // Entry to latch at the next step boundary; 4-bit add wraps 15 -> 0.
    assign load_idx_d   = (state_q == PLAY && step_q != last_step) ? step_q + 4'd1 : 4'd0;
    assign load_entry_d = pattern_q[load_idx_d];
    assign tick_wrap_d  = (tick_q == TICK_LAST);
    assign step_end_d   = tick_wrap_d && (beat_q == dur_q);
    assign gap_edge_d   = (tick_q == TICK_GAP) && (beat_q == dur_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                pattern_q[i] <= '0;
            end
        end else if (wr_en) begin
            pattern_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            beat_q  <= '0;
            dur_q   <= '0;
            step_q  <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q <= PLAY;
                        busy_q  <= 1'b1;
                        step_q  <= load_idx_d;
                        note_q  <= load_entry_d[5:3];
                        gate_q  <= |load_entry_d[5:3];
                        dur_q   <= load_entry_d[2:0];
                        tick_q  <= '0;
                        beat_q  <= '0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        step_q  <= '0;
                        note_q  <= '0;
                        gate_q  <= 1'b0;
                        tick_q  <= '0;
                        beat_q  <= '0;
                    end else if (step_end_d) begin
                        if (step_q == last_step && !loop) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            step_q  <= '0;
                            note_q  <= '0;
                            gate_q  <= 1'b0;
                            tick_q  <= '0;
                            beat_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q  <= load_idx_d;
                            note_q  <= load_entry_d[5:3];
                            gate_q  <= |load_entry_d[5:3];
                            dur_q   <= load_entry_d[2:0];
                            tick_q  <= '0;
                            beat_q  <= '0;
                        end
                    end else begin
                        if (tick_wrap_d) begin
                            tick_q <= '0;
                            beat_q <= beat_q + 3'd1;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                        // Gate drops GAP_TICKS cycles before the step ends.
                        if (gap_edge_d) begin
                            gate_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign note = note_q;
    assign gate = gate_q;
    assign step = step_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
